// File: rtl/apb_req_master.sv
// APB4 requester: pops one request from the request FIFO, runs it as a single APB
// transfer (with optional PREADY timeout) and pushes exactly one response entry.
module apb_req_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      req_empty_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic                      req_write_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   req_strb_i,
    input  logic [2:0]                req_prot_i,
    output logic                      req_pop_o,

    input  logic                      rsp_full_i,
    output logic                      rsp_push_o,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                      rsp_err_o,

    output logic [ADDR_WIDTH-1:0]     paddr_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [DATA_WIDTH-1:0]     pwdata_o,
    output logic [DATA_WIDTH/8-1:0]   pstrb_o,
    output logic [2:0]                pprot_o,
    input  logic [DATA_WIDTH-1:0]     prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    // A zero timeout still needs a legal 1-bit counter; it is simply never advanced.
    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] strb_q,  strb_d;
    logic [2:0]            prot_q,  prot_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q,   err_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    logic                  pop_c;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  timeout_hit;

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        prot_d  = prot_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        pop_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Holding off while the response FIFO is full reserves a slot for this transfer.
                if (!req_empty_i && !rsp_full_i) begin
                    pop_c   = 1'b1;
                    addr_d  = req_addr_i;
                    write_d = req_write_i;
                    wdata_d = req_wdata_i;
                    strb_d  = req_strb_i;
                    prot_d  = req_prot_i;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    rdata_d = write_q ? '0 : prdata_i;
                    err_d   = pslverr_i;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset gates the pop directly since IDLE is the reset state.
    assign req_pop_o   = pop_c && !rst_i;

    assign psel_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable_o   = (state_q == ST_ACCESS);
    assign paddr_o     = addr_q;
    assign pwrite_o    = write_q;
    assign pwdata_o    = wdata_q;
    assign pstrb_o     = write_q ? strb_q : '0;
    assign pprot_o     = prot_q;

    assign rsp_push_o  = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master: a vector table of single transfers plus
// hand-written back-pressure, back-to-back and mid-transfer reset sequences.
module tb_apb_req_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_empty_i;
    logic [AW-1:0] req_addr_i;
    logic          req_write_i;
    logic [DW-1:0] req_wdata_i;
    logic [SW-1:0] req_strb_i;
    logic [2:0]    req_prot_i;
    logic          req_pop_o;
    logic          rsp_full_i;
    logic          rsp_push_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic [AW-1:0] paddr_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [DW-1:0] pwdata_o;
    logic [SW-1:0] pstrb_o;
    logic [2:0]    pprot_o;
    logic [DW-1:0] prdata_i;
    logic          pready_i;
    logic          pslverr_i;

    apb_req_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_empty_i (req_empty_i),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_wdata_i (req_wdata_i),
        .req_strb_i  (req_strb_i),
        .req_prot_i  (req_prot_i),
        .req_pop_o   (req_pop_o),
        .rsp_full_i  (rsp_full_i),
        .rsp_push_o  (rsp_push_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .paddr_o     (paddr_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .pwdata_o    (pwdata_o),
        .pstrb_o     (pstrb_o),
        .pprot_o     (pprot_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int            waits;      // ACCESS cycles with PREADY low before the ready cycle
        logic          ready;      // 0: PREADY never rises, expect timeout
        logic [DW-1:0] prdata;
        logic          slverr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[6];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int   n_acc;
        logic last;
        @(negedge clk_i);
        req_empty_i = 1'b0;
        req_addr_i  = v.addr;
        req_write_i = v.write;
        req_wdata_i = v.wdata;
        req_strb_i  = v.strb;
        req_prot_i  = v.prot;
        pready_i    = 1'b0;
        #1 check($sformatf("v%0d pop", id), 64'(req_pop_o), 64'd1);

        @(negedge clk_i);
        req_empty_i = 1'b1;
        req_addr_i  = ~v.addr;
        req_write_i = ~v.write;
        req_wdata_i = ~v.wdata;
        req_strb_i  = ~v.strb;
        req_prot_i  = ~v.prot;
        check($sformatf("v%0d setup psel", id),    64'(psel_o),    64'd1);
        check($sformatf("v%0d setup penable", id), 64'(penable_o), 64'd0);
        check($sformatf("v%0d setup paddr", id),   64'(paddr_o),   64'(v.addr));
        check($sformatf("v%0d setup pwrite", id),  64'(pwrite_o),  64'(v.write));
        check($sformatf("v%0d setup pwdata", id),  64'(pwdata_o),  64'(v.wdata));
        check($sformatf("v%0d setup pstrb", id),   64'(pstrb_o),   v.write ? 64'(v.strb) : 64'd0);
        check($sformatf("v%0d setup pprot", id),   64'(pprot_o),   64'(v.prot));

        n_acc = v.ready ? v.waits + 1 : v.waits;
        for (int w = 0; w < n_acc; w++) begin
            @(negedge clk_i);
            last      = v.ready && (w == n_acc - 1);
            pready_i  = last;
            prdata_i  = last ? v.prdata : (32'hBAD0_0000 + 32'(w));
            pslverr_i = last ? v.slverr : 1'b1;
            check($sformatf("v%0d acc%0d psel", id, w),    64'(psel_o),    64'd1);
            check($sformatf("v%0d acc%0d penable", id, w), 64'(penable_o), 64'd1);
            check($sformatf("v%0d acc%0d paddr", id, w),   64'(paddr_o),   64'(v.addr));
            check($sformatf("v%0d acc%0d pwdata", id, w),  64'(pwdata_o),  64'(v.wdata));
            check($sformatf("v%0d acc%0d pstrb", id, w),   64'(pstrb_o),   v.write ? 64'(v.strb) : 64'd0);
        end

        @(negedge clk_i);
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        check($sformatf("v%0d resp push", id),  64'(rsp_push_o),  64'd1);
        check($sformatf("v%0d resp psel", id),  64'(psel_o),      64'd0);
        check($sformatf("v%0d resp pen", id),   64'(penable_o),   64'd0);
        check($sformatf("v%0d resp rdata", id), 64'(rsp_rdata_o), 64'(v.exp_rdata));
        check($sformatf("v%0d resp err", id),   64'(rsp_err_o),   64'(v.exp_err));

        @(negedge clk_i);
        check($sformatf("v%0d post push", id),  64'(rsp_push_o),  64'd0);
        check($sformatf("v%0d held rdata", id), 64'(rsp_rdata_o), 64'(v.exp_rdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t b2b[4];
        int   idx, pushes;
        int   pop_cyc[4];
        int   push_cyc[4];

        //              wr    addr           wdata          strb  prot  waits rdy prdata         slverr exp_rdata      exp_err
        vecs[0] = '{1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'd0, 0,  1'b1, 32'h0BAD_F00D, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h1111_2222, 4'hA, 3'd1, 3,  1'b1, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0, 3'd3, 0,  1'b1, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0088, 32'h0000_55AA, 4'h5, 3'd2, 1,  1'b1, 32'h7777_7777, 1'b1, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 3'd0, 16, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0104, 32'h0000_0000, 4'h0, 3'd4, 15, 1'b1, 32'h0000_0077, 1'b0, 32'h0000_0077, 1'b0};

        rst_i       = 1'b1;
        req_empty_i = 1'b0;
        rsp_full_i  = 1'b0;
        req_addr_i  = 32'h1;
        req_write_i = 1'b1;
        req_wdata_i = 32'h1;
        req_strb_i  = 4'hF;
        req_prot_i  = 3'd7;
        prdata_i    = '0;
        pready_i    = 1'b1;
        pslverr_i   = 1'b1;

        #2;
        check("rst pop",   64'(req_pop_o),   64'd0);
        check("rst psel",  64'(psel_o),      64'd0);
        check("rst pen",   64'(penable_o),   64'd0);
        check("rst push",  64'(rsp_push_o),  64'd0);
        check("rst rdata", 64'(rsp_rdata_o), 64'd0);
        check("rst err",   64'(rsp_err_o),   64'd0);
        check("rst paddr", 64'(paddr_o),     64'd0);
        check("rst pstrb", 64'(pstrb_o),     64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst hold psel", 64'(psel_o), 64'd0);
        req_empty_i = 1'b1;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;
        rst_i       = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Back-pressure: full response FIFO blocks the pop.
        @(negedge clk_i);
        rsp_full_i  = 1'b1;
        req_empty_i = 1'b0;
        req_addr_i  = 32'h0000_0300;
        req_write_i = 1'b0;
        req_strb_i  = 4'hF;
        req_prot_i  = 3'd0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("bp%0d pop", c),  64'(req_pop_o), 64'd0);
            check($sformatf("bp%0d psel", c), 64'(psel_o),    64'd0);
            @(negedge clk_i);
        end
        rsp_full_i = 1'b0;
        #1 check("bp release pop", 64'(req_pop_o), 64'd1);
        @(negedge clk_i);
        req_empty_i = 1'b1;
        check("bp setup paddr", 64'(paddr_o), 64'h300);
        @(negedge clk_i);
        pready_i = 1'b1;
        prdata_i = 32'h0000_0BB0;
        @(negedge clk_i);
        pready_i = 1'b0;
        check("bp push",  64'(rsp_push_o),  64'd1);
        check("bp rdata", 64'(rsp_rdata_o), 64'h0BB0);

        // Back-to-back: four queued requests with a zero-wait slave.
        b2b[0] = '{1'b1, 32'h0000_1000, 32'hAAAA_0001, 4'h3, 3'd0, 0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0};
        b2b[1] = '{1'b0, 32'h0000_1004, 32'h0,         4'hF, 3'd1, 0, 1'b1, 32'h0, 1'b0, 32'h0000_1004 ^ RD_KEY, 1'b0};
        b2b[2] = '{1'b0, 32'h0000_1008, 32'h0,         4'hF, 3'd2, 0, 1'b1, 32'h0, 1'b0, 32'h0000_1008 ^ RD_KEY, 1'b0};
        b2b[3] = '{1'b1, 32'h0000_100C, 32'hAAAA_0004, 4'hC, 3'd3, 0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0};
        idx    = 0;
        pushes = 0;
        pready_i  = 1'b1;
        pslverr_i = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk_i);
            if (idx < 4) begin
                req_empty_i = 1'b0;
                req_addr_i  = b2b[idx].addr;
                req_write_i = b2b[idx].write;
                req_wdata_i = b2b[idx].wdata;
                req_strb_i  = b2b[idx].strb;
                req_prot_i  = b2b[idx].prot;
            end else begin
                req_empty_i = 1'b1;
            end
            prdata_i = paddr_o ^ RD_KEY;
            #1;
            if (rsp_push_o) begin
                if (pushes < 4) begin
                    check($sformatf("b2b push%0d rdata", pushes), 64'(rsp_rdata_o), 64'(b2b[pushes].exp_rdata));
                    check($sformatf("b2b push%0d err", pushes),   64'(rsp_err_o),   64'd0);
                    push_cyc[pushes] = cyc;
                end
                pushes++;
            end
            if (req_pop_o) begin
                check($sformatf("b2b pop%0d overlap", idx), 64'({psel_o, rsp_push_o}), 64'd0);
                if (idx < 4) pop_cyc[idx] = cyc;
                idx++;
            end
        end
        pready_i = 1'b0;
        check("b2b pops",   64'(idx),    64'd4);
        check("b2b pushes", 64'(pushes), 64'd4);
        if (idx == 4 && pushes == 4) begin
            for (int k = 0; k < 4; k++) begin
                if (k > 0) check($sformatf("b2b pop gap%0d", k), 64'(pop_cyc[k] - pop_cyc[k-1]), 64'd4);
                check($sformatf("b2b latency%0d", k), 64'(push_cyc[k] - pop_cyc[k]), 64'd3);
            end
        end

        // Reset during ACCESS abandons the transfer without a response.
        @(negedge clk_i);
        req_empty_i = 1'b0;
        req_addr_i  = 32'h0000_0500;
        req_write_i = 1'b1;
        req_wdata_i = 32'h5555_5555;
        req_strb_i  = 4'hF;
        req_prot_i  = 3'd0;
        @(negedge clk_i);
        req_empty_i = 1'b1;
        @(negedge clk_i);
        check("rmt access pen", 64'(penable_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        check("rmt psel",  64'(psel_o),     64'd0);
        check("rmt pen",   64'(penable_o),  64'd0);
        check("rmt push",  64'(rsp_push_o), 64'd0);
        check("rmt pstrb", 64'(pstrb_o),    64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check($sformatf("rmt idle%0d push", c), 64'(rsp_push_o), 64'd0);
            check($sformatf("rmt idle%0d psel", c), 64'(psel_o),     64'd0);
        end
        run_vec(10, vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
